// File: rtl/wb_sram_slave_if.sv
// Wishbone classic bus bundle shared by wb_sram_slave and its masters.
interface wb_bus_t;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic        ack;
  logic        err;

  modport slave  (input  cyc, stb, we, sel, adr, dat_ms,
                  output dat_sm, ack, err);
  modport master (output cyc, stb, we, sel, adr, dat_ms,
                  input  dat_sm, ack, err);
endinterface

// File: rtl/wb_sram_slave.sv
// Wishbone SRAM responder with a fixed, parameterised response latency.
// Requests are latched in IDLE, delayed WAIT_STATES cycles, then answered
// in a single RESP cycle. Optional macro WB_SRAM_ERR_EN turns out-of-range
// accesses into err responses; without it they alias into the array.
module wb_sram_slave #(
  parameter int unsigned N_WORDS     = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input logic    clk,
  input logic    rstn_i,
  wb_bus_t.slave wb_bus
);

  localparam int unsigned AW      = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [3:0]  WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    r_state;
  logic [3:0]    r_cnt;
  logic [31:0]   r_adr;
  logic          r_we;
  logic [3:0]    r_sel;
  logic [31:0]   r_dat_ms;
  logic          r_ack;
  logic          r_err;
  logic [31:0]   r_dat_sm;
  logic [31:0]   r_mem [N_WORDS];

  logic [1:0]    w_state_nxt;
  logic [3:0]    w_cnt_nxt;
  logic          w_ack_nxt;
  logic          w_err_nxt;
  logic [31:0]   w_dat_nxt;
  logic          w_accept;
  logic [31:0]   w_adr;
  logic          w_we;
  logic [31:0]   w_off;
  logic [AW-1:0] w_idx;
  logic          w_oor;
  logic          w_wr_en;

  // In IDLE the request being decoded is still on the bus; afterwards it is the latched copy.
  assign w_accept = (r_state == S_IDLE) && wb_bus.cyc && wb_bus.stb;
  assign w_adr    = (r_state == S_IDLE) ? wb_bus.adr : r_adr;
  assign w_we     = (r_state == S_IDLE) ? wb_bus.we  : r_we;
  assign w_off    = w_adr - BASE_ADDR;
  assign w_idx    = AW'(w_off >> 2);

`ifdef WB_SRAM_ERR_EN
  localparam logic [32:0] END_ADDR = 33'(BASE_ADDR) + (33'(N_WORDS) << 2);
  // Out-of-range decode, widened so BASE_ADDR + size cannot wrap.
  assign w_oor = ({1'b0, w_adr} < 33'(BASE_ADDR)) || ({1'b0, w_adr} >= END_ADDR);
`else
  // Out-of-range addresses alias into the array and are served normally.
  assign w_oor = 1'b0;
`endif

  // Next-state, wait counter and response decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ack_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    w_dat_nxt   = 32'h0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (WAIT_STATES > 0) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = WS_LOAD;
          end else begin
            w_state_nxt = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (!wb_bus.cyc) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 4'd0;
        end else if (r_cnt == 4'd0) begin
          w_state_nxt = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
    if (w_state_nxt == S_RESP) begin
      w_ack_nxt = !w_oor;
      w_err_nxt = w_oor;
      w_dat_nxt = (!w_we && !w_oor) ? r_mem[w_idx] : 32'h0;
    end
  end

  // State, counter, request latch and registered response.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_adr    <= 32'h0;
      r_we     <= 1'b0;
      r_sel    <= 4'h0;
      r_dat_ms <= 32'h0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_dat_sm <= 32'h0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_ack    <= w_ack_nxt;
      r_err    <= w_err_nxt;
      r_dat_sm <= w_dat_nxt;
      if (w_accept) begin
        r_adr    <= wb_bus.adr;
        r_we     <= wb_bus.we;
        r_sel    <= wb_bus.sel;
        r_dat_ms <= wb_bus.dat_ms;
      end
    end
  end

  // Writes commit only at the end of a RESP cycle the master still owns.
  assign w_wr_en = (r_state == S_RESP) && wb_bus.cyc && r_we && !w_oor;

  // Byte-lane write into the array; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (r_sel[i]) r_mem[w_idx][8*i +: 8] <= r_dat_ms[8*i +: 8];
      end
    end
  end

  // Responses vanish as soon as the master abandons the cycle.
  assign wb_bus.ack    = r_ack & wb_bus.cyc;
  assign wb_bus.err    = r_err & wb_bus.cyc;
  assign wb_bus.dat_sm = wb_bus.cyc ? r_dat_sm : 32'h0;

endmodule
